echo_requester: RTL and testbench
=================================

Name: echo_requester

Overview:
- Initiator side of the echo request/indication interface.
- Issues a programmed burst of echoReq transactions carrying a deterministic data sequence to an echo responder.
- Accepts the returning echo indications, checks each one in order against the value sent, and reports counts, errors and timeout.
- Sits between a host/test controller (start/status) and the echo responder's request and indication ports.

Parameters:
- MAX_OUTSTANDING, 4, maximum requests in flight awaiting indication (1..255).
- TIMEOUT, 1024, idle cycles with requests outstanding before abort (≥1).

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- start__ENA  input  1  launch a burst; only asserted while start__RDY=1.
- start_count  input  16  number of requests in the burst.
- start_seed  input  32  data value of request 0.
- start__RDY  output  1  high in IDLE and DONE.
- echoReq__ENA  output  1  request issue; asserted only when echoReq__RDY=1.
- echoReq_v  output  32  request data.
- echoReq__RDY  input  1  responder can accept a request.
- echo__ENA  input  1  indication valid.
- echo_v  input  32  indication data.
- echo__RDY  output  1  requester can accept an indication.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- timeout  output  1  burst aborted by watchdog.
- sent_count  output  16  requests issued this burst.
- recv_count  output  16  indications accepted this burst.
- err_count  output  16  mismatched or spurious indications; saturates at 16'hFFFF.

Behaviour:
- Reset (RST=1 at edge): state=IDLE; all counters, outstanding, watchdog and timeout=0; done=0, busy=0. Combinational outputs reset to echoReq__ENA=0, echoReq_v=0, echo__RDY=0, start__RDY=1. RST mid-burst abandons the burst with no further requests.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start__ENA:
  - Latch count and seed; clear sent/recv/err/outstanding/timeout/watchdog.
  - Go to RUN, or to DONE next cycle if count=0.
  - A new start from DONE is accepted identically.
- RUN:
  - echoReq__ENA = echoReq__RDY & (sent_count<count) & (outstanding<MAX_OUTSTANDING).
  - echoReq_v = seed + sent_count, mod 2^32, zero-extended index; valid only while ENA=1, else 0.
  - Each ENA cycle: sent_count+1, outstanding+1.
  - When sent_count reaches count, go to DRAIN the following cycle.
- echo__RDY = 1 in RUN and DRAIN, 0 otherwise. An echo__ENA while echo__RDY=0 is ignored.
- Indication accepted (echo__ENA & echo__RDY):
  - If outstanding>0: expected = seed + recv_count; recv_count+1, outstanding−1, and err_count+1 if echo_v≠expected.
  - If outstanding=0 (spurious): err_count+1; recv_count and outstanding unchanged.
- Same-cycle issue and accept: outstanding unchanged; both counters update.
- DRAIN: when outstanding=0 and recv_count=count, go to DONE.
- Watchdog:
  - Counts cycles in RUN/DRAIN with outstanding>0 and no indication accepted; cleared on any accepted indication or when outstanding=0.
  - Reaching TIMEOUT sets timeout=1 and goes to DONE. Outstanding requests are abandoned; later indications are ignored (echo__RDY=0).
- Latency:
  - First echoReq__ENA no earlier than the cycle after start acceptance.
  - Back-to-back issue every cycle while RDY and window allow.
  - done rises the cycle after the final indication is accepted.
- Status outputs hold their values in DONE until the next start or reset.

Test Plan:
- count=4, seed=0x100, responder echoes with 1-cycle latency, RDY always high → echoReq_v 0x100..0x103 on consecutive cycles; done with sent=recv=4, err=0, timeout=0.
- count=10, MAX_OUTSTANDING=4, responder withholds indications for 20 cycles → exactly 4 requests issued, echoReq__ENA held low while outstanding=4; after release all 10 complete, err=0.
- count=3, seed=0xFFFFFFFF, responder returns 2nd value XOR 1 → values 0xFFFFFFFF, 0x0, 0x1 sent (wrap); done with recv=3, err=1.
- count=5, responder drops 3rd indication → timeout=1 TIMEOUT cycles after the last accepted indication; done, recv=2; a late indication is not accepted.
- Spurious echo__ENA in RUN with outstanding=0, then count=0 start from DONE → err_count increments once; count=0 reaches done the next cycle with all counters 0.
- RST asserted mid-burst with 2 requests outstanding → next cycle IDLE, all outputs at reset values, no echoReq__ENA until a new start.

Source files
------------

// File: rtl/echo_requester.sv
// Initiator side of the echo request/indication interface: issues a burst of
// sequential data words, checks returning indications in order, reports status.
module echo_requester #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start__ENA,
  input  logic [15:0] start_count,
  input  logic [31:0] start_seed,
  output logic        start__RDY,
  output logic        echoReq__ENA,
  output logic [31:0] echoReq_v,
  input  logic        echoReq__RDY,
  input  logic        echo__ENA,
  input  logic [31:0] echo_v,
  output logic        echo__RDY,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] sent_count,
  output logic [15:0] recv_count,
  output logic [15:0] err_count
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state, state_n;
  logic [15:0]    count_q, count_n;
  logic [31:0]    seed_q, seed_n;
  logic [15:0]    sent_n, recv_n, err_n;
  logic [7:0]     outstanding, out_n;
  logic [WDW-1:0] watchdog, wd_n;
  logic           timeout_n;
  logic           issue, accept, matched, err_inc;

  assign start__RDY   = (state == IDLE) || (state == DONE);
  assign echo__RDY    = (state == RUN) || (state == DRAIN);
  assign busy         = echo__RDY;
  assign done         = (state == DONE);
  assign issue        = (state == RUN) && echoReq__RDY && (sent_count < count_q) &&
                        (outstanding < 8'(MAX_OUTSTANDING));
  assign echoReq__ENA = issue;
  assign echoReq_v    = issue ? (seed_q + {16'h0, sent_count}) : 32'h0;
  assign accept       = echo__ENA && echo__RDY;
  // An accepted indication only retires a request if one is actually in flight.
  assign matched      = accept && (outstanding != 8'd0);

  always_comb begin
    state_n   = state;
    count_n   = count_q;
    seed_n    = seed_q;
    sent_n    = sent_count;
    recv_n    = recv_count;
    err_n     = err_count;
    out_n     = outstanding;
    wd_n      = watchdog;
    timeout_n = timeout;
    err_inc   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start__ENA) begin
          count_n   = start_count;
          seed_n    = start_seed;
          sent_n    = '0;
          recv_n    = '0;
          err_n     = '0;
          out_n     = '0;
          wd_n      = '0;
          timeout_n = 1'b0;
          state_n   = (start_count == 16'd0) ? DONE : RUN;
        end
      end
      RUN, DRAIN: begin
        if (matched) begin
          recv_n = recv_count + 16'd1;
          if (echo_v != (seed_q + {16'h0, recv_count}))
            err_inc = 1'b1;
        end else if (accept) begin
          err_inc = 1'b1;
        end
        if (err_inc && (err_count != 16'hFFFF))
          err_n = err_count + 16'd1;
        if (issue)
          sent_n = sent_count + 16'd1;
        if (issue && !matched)
          out_n = outstanding + 8'd1;
        else if (!issue && matched)
          out_n = outstanding - 8'd1;

        // Watchdog measures silence while the responder owes us indications.
        if (accept || (outstanding == 8'd0))
          wd_n = '0;
        else
          wd_n = watchdog + 1'b1;

        if (!accept && (outstanding != 8'd0) && (watchdog == WDW'(TIMEOUT - 1))) begin
          timeout_n = 1'b1;
          state_n   = DONE;
        end else if ((sent_n == count_q) && (recv_n == count_q) && (out_n == 8'd0)) begin
          state_n = DONE;
        end else if (sent_n == count_q) begin
          state_n = DRAIN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      count_q     <= '0;
      seed_q      <= '0;
      sent_count  <= '0;
      recv_count  <= '0;
      err_count   <= '0;
      outstanding <= '0;
      watchdog    <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      count_q     <= count_n;
      seed_q      <= seed_n;
      sent_count  <= sent_n;
      recv_count  <= recv_n;
      err_count   <= err_n;
      outstanding <= out_n;
      watchdog    <= wd_n;
      timeout     <= timeout_n;
    end
  end

endmodule

// File: tb/tb_echo_requester.sv
// Self-checking bench for echo_requester: a scripted/randomized responder plus a
// transaction-level model of the burst that is compared against the DUT every cycle.
module tb_echo_requester;

  localparam int MAXO = 4;
  localparam int TMO  = 40;
  localparam int BIG  = 1 << 30;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start__ENA = 1'b0;
  logic [15:0] start_count = '0;
  logic [31:0] start_seed = '0;
  logic        start__RDY;
  logic        echoReq__ENA;
  logic [31:0] echoReq_v;
  logic        echoReq__RDY = 1'b0;
  logic        echo__ENA = 1'b0;
  logic [31:0] echo_v = '0;
  logic        echo__RDY;
  logic        busy, done, timeout;
  logic [15:0] sent_count, recv_count, err_count;

  echo_requester #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .start__ENA(start__ENA), .start_count(start_count), .start_seed(start_seed),
    .start__RDY(start__RDY),
    .echoReq__ENA(echoReq__ENA), .echoReq_v(echoReq_v), .echoReq__RDY(echoReq__RDY),
    .echo__ENA(echo__ENA), .echo_v(echo_v), .echo__RDY(echo__RDY),
    .busy(busy), .done(done), .timeout(timeout),
    .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder knobs and state
  typedef struct { logic [31:0] v; int due; } item_t;
  item_t       rq[$];
  logic [31:0] cap_v[$];
  int          cap_c[$];
  int cap_n = 0, resp_idx = 0;
  int lat = 1, rdy_prob = 100, resp_prob = 100, rdy_limit = BIG, stop_after = BIG;
  int corrupt_idx = -1;
  bit hold = 0, spurious = 0;

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      echoReq__RDY = (cap_n < rdy_limit) && ($urandom_range(0, 99) < rdy_prob);
      echo__ENA = 1'b0;
      echo_v = $urandom;
      if (spurious) begin
        echo__ENA = 1'b1;
        echo_v = 32'hDEAD_BEEF;
        spurious = 0;
      end else if (!hold && rq.size() > 0 && rq[0].due <= cyc && resp_idx < stop_after &&
                   $urandom_range(0, 99) < resp_prob) begin
        item_t it;
        it = rq.pop_front();
        echo__ENA = 1'b1;
        echo_v = (resp_idx == corrupt_idx) ? (it.v ^ 32'h1) : it.v;
        resp_idx++;
      end
    end
  end

  always @(negedge CLK) begin
    if (echoReq__ENA === 1'b1 && echoReq__RDY === 1'b1) begin
      rq.push_back('{echoReq_v, cyc + lat});
      cap_v.push_back(echoReq_v);
      cap_c.push_back(cyc);
      cap_n++;
    end
  end

  // Transaction-level model: outstanding is simply sent minus received.
  bit          m_valid = 0, m_active = 0, m_finished = 0, m_timeout = 0;
  int          m_count = 0, m_sent = 0, m_recv = 0, m_err = 0, m_idle = 0;
  logic [31:0] m_seed = '0;

  always @(negedge CLK) begin
    bit exp_issue, acc;
    int owed;
    exp_issue = m_active && (echoReq__RDY === 1'b1) && (m_sent < m_count) &&
                ((m_sent - m_recv) < MAXO);
    if (m_valid) begin
      checkOutput("start_rdy", start__RDY, !m_active);
      checkOutput("busy", busy, m_active);
      checkOutput("echo_rdy", echo__RDY, m_active);
      checkOutput("done", done, m_finished);
      checkOutput("timeout", timeout, m_timeout);
      checkOutput("req_ena", echoReq__ENA, exp_issue);
      checkOutput("req_v", echoReq_v, exp_issue ? (m_seed + 32'(m_sent)) : 32'h0);
      checkOutput("sent", sent_count, m_sent);
      checkOutput("recv", recv_count, m_recv);
      checkOutput("err", err_count, m_err);
    end
    if (RST) begin
      m_valid = 1; m_active = 0; m_finished = 0; m_timeout = 0;
      m_count = 0; m_seed = '0; m_sent = 0; m_recv = 0; m_err = 0; m_idle = 0;
    end else if (m_valid) begin
      if (!m_active) begin
        if (start__ENA) begin
          m_count = int'(start_count); m_seed = start_seed;
          m_sent = 0; m_recv = 0; m_err = 0; m_idle = 0; m_timeout = 0;
          m_active = (m_count != 0);
          m_finished = (m_count == 0);
        end
      end else begin
        acc = (echo__ENA === 1'b1);
        owed = m_sent - m_recv;
        if (acc) begin
          if (owed > 0) begin
            if (echo_v !== m_seed + 32'(m_recv) && m_err < 65535) m_err++;
            m_recv++;
          end else if (m_err < 65535) begin
            m_err++;
          end
        end
        if (exp_issue) m_sent++;
        m_idle = (owed > 0 && !acc) ? m_idle + 1 : 0;
        if (m_idle == TMO) begin
          m_timeout = 1; m_active = 0; m_finished = 1;
        end else if (m_sent == m_count && m_recv == m_count) begin
          m_active = 0; m_finished = 1;
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input logic [31:0] s);
    @(posedge CLK); #2;
    rq.delete(); cap_v.delete(); cap_c.delete();
    cap_n = 0; resp_idx = 0;
    start__ENA = 1'b1; start_count = 16'(n); start_seed = s;
    @(posedge CLK); #2;
    start__ENA = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done === 1'b1) break;
    end
    checkOutput("done_reached", done, 1'b1);
  endtask

  logic [31:0] exp_wrap[3];

  initial begin
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    checkOutput("rst_start_rdy", start__RDY, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_req_ena", echoReq__ENA, 1'b0);
    checkOutput("rst_sent", sent_count, 16'd0);

    // Basic burst, 1-cycle echo latency
    lat = 1;
    applyStimulus(4, 32'h100);
    waitDone(200);
    checkOutput("t1_ncap", cap_n, 4);
    for (int k = 0; k < cap_v.size(); k++) begin
      checkOutput("t1_value", cap_v[k], 32'h100 + 32'(k));
      if (k > 0) checkOutput("t1_back_to_back", cap_c[k] - cap_c[k-1], 1);
    end
    checkOutput("t1_recv", recv_count, 16'd4);
    checkOutput("t1_err", err_count, 16'd0);
    checkOutput("t1_timeout", timeout, 1'b0);

    // Outstanding window held full while responder is silent
    hold = 1;
    applyStimulus(10, 32'h5000);
    repeat (20) @(negedge CLK);
    checkOutput("t2_sent_window", sent_count, 16'd4);
    checkOutput("t2_req_ena_low", echoReq__ENA, 1'b0);
    hold = 0;
    waitDone(300);
    checkOutput("t2_recv", recv_count, 16'd10);
    checkOutput("t2_err", err_count, 16'd0);

    // Seed wrap with one corrupted echo
    corrupt_idx = 1;
    applyStimulus(3, 32'hFFFF_FFFF);
    waitDone(200);
    corrupt_idx = -1;
    exp_wrap = '{32'hFFFF_FFFF, 32'h0, 32'h1};
    checkOutput("t3_ncap", cap_n, 3);
    for (int k = 0; k < cap_v.size() && k < 3; k++) checkOutput("t3_value", cap_v[k], exp_wrap[k]);
    checkOutput("t3_recv", recv_count, 16'd3);
    checkOutput("t3_err", err_count, 16'd1);

    // Responder stops after two echoes -> watchdog abort, late echoes ignored
    stop_after = 2;
    applyStimulus(5, 32'h7700_0000);
    waitDone(TMO + 100);
    checkOutput("t4_timeout", timeout, 1'b1);
    checkOutput("t4_recv", recv_count, 16'd2);
    checkOutput("t4_sent", sent_count, 16'd5);
    stop_after = BIG;
    repeat (8) @(negedge CLK);
    checkOutput("t4_late_recv", recv_count, 16'd2);
    checkOutput("t4_late_err", err_count, 16'd0);
    checkOutput("t4_late_done", done, 1'b1);

    // Spurious indication with nothing outstanding, then a zero-length burst
    rdy_limit = 0;
    applyStimulus(2, 32'h1234_0000);
    repeat (2) @(negedge CLK);
    spurious = 1;
    repeat (2) @(negedge CLK);
    checkOutput("t5_spur_err", err_count, 16'd1);
    checkOutput("t5_spur_recv", recv_count, 16'd0);
    rdy_limit = BIG;
    waitDone(200);
    checkOutput("t5_err_final", err_count, 16'd1);
    checkOutput("t5_recv_final", recv_count, 16'd2);
    applyStimulus(0, 32'hABCD_0123);
    @(negedge CLK);
    checkOutput("t5_zero_done", done, 1'b1);
    checkOutput("t5_zero_sent", sent_count, 16'd0);
    checkOutput("t5_zero_err", err_count, 16'd0);

    // Reset in the middle of a burst with two requests in flight
    hold = 1; rdy_limit = 2;
    applyStimulus(8, 32'h9000);
    repeat (4) @(negedge CLK);
    checkOutput("t6_sent_before", sent_count, 16'd2);
    @(posedge CLK); #2 RST = 1'b1; rq.delete();
    @(posedge CLK); #2 RST = 1'b0;
    @(negedge CLK);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_start_rdy", start__RDY, 1'b1);
    checkOutput("t6_echo_rdy", echo__RDY, 1'b0);
    checkOutput("t6_sent", sent_count, 16'd0);
    hold = 0; rdy_limit = BIG;
    repeat (5) @(negedge CLK);
    checkOutput("t6_no_issue", cap_n, 2);

    // Randomized bursts
    for (int b = 0; b < 8; b++) begin
      lat = $urandom_range(1, 6);
      rdy_prob = $urandom_range(40, 100);
      resp_prob = $urandom_range(70, 100);
      corrupt_idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1;
      applyStimulus($urandom_range(1, 24), $urandom);
      waitDone(3000);
      checkOutput("rand_timeout", timeout, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
